// File: rtl/sd_access_arbiter.sv
// Two-port round-robin front end for sd_controller: latches the winning block
// command, strobes the controller once, steers byte streams and checks the byte count.
module sd_access_arbiter #(
    parameter int unsigned BLK_BYTES = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_wr,
    input  logic [63:0] i_blk_num,
    input  logic [63:0] i_adr,
    input  logic [15:0] i_wdata,
    output logic [1:0]  o_ack,
    output logic [1:0]  o_done,
    output logic        o_err,
    output logic [7:0]  o_rd_data,
    output logic [1:0]  o_rd_en,
    output logic [1:0]  o_wr_req,
    output logic        o_busy,
    output logic        o_sd_ren,
    output logic        o_sd_wen,
    output logic [31:0] o_sd_blk_num,
    output logic [31:0] o_sd_adr,
    output logic [7:0]  o_sd_data,
    input  logic        i_sd_ready,
    input  logic [7:0]  i_sd_data,
    input  logic        i_sd_data_en,
    input  logic        i_sd_data_ready
);

    localparam int unsigned CNT_W = 41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_XFER,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;
    logic               r_wr;
    logic               r_last;
    logic [31:0]        r_blk_num;
    logic [31:0]        r_adr;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_ack;
    logic [1:0]         r_done;
    logic               r_err;
    logic               r_sd_ren;
    logic               r_sd_wen;

    logic               w_grant;
    logic               w_gnt_port;
    logic [31:0]        w_gnt_blk;
    logic [31:0]        w_gnt_adr;
    logic               w_byte;
    logic               w_rd_xfer;
    logic               w_wr_xfer;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_expect;
    logic               w_done_set;
    logic               w_err_set;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    assign w_grant    = (r_state == S_IDLE) && i_sd_ready && (i_req != 2'b00);
    assign w_gnt_port = (i_req == 2'b11) ? ~r_last : i_req[1];
    assign w_gnt_blk  = w_gnt_port ? i_blk_num[63:32] : i_blk_num[31:0];
    assign w_gnt_adr  = w_gnt_port ? i_adr[63:32]     : i_adr[31:0];

    assign w_rd_xfer  = (r_state == S_XFER) && !r_wr && i_sd_data_en;
    assign w_wr_xfer  = (r_state == S_XFER) &&  r_wr && i_sd_data_ready;
    assign w_byte     = w_rd_xfer || w_wr_xfer;
    assign w_cnt_next = r_cnt + CNT_W'(w_byte);
    assign w_expect   = CNT_W'(r_blk_num) * CNT_W'(BLK_BYTES);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero-block command completes from DONE without ever reaching the controller.
    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = (w_gnt_blk == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!i_sd_ready) w_next = S_XFER;
            S_XFER: begin
                if (i_sd_ready) begin
                    w_next     = S_DONE;
                    w_done_set = 1'b1;
                    w_err_set  = (w_cnt_next != w_expect);
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (r_blk_num == 32'd0) begin
                    w_done_set = 1'b1;
                    w_err_set  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner   <= 1'b0;
            r_wr      <= 1'b0;
            r_last    <= 1'b1;
            r_blk_num <= '0;
            r_adr     <= '0;
            r_cnt     <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_sd_ren  <= 1'b0;
            r_sd_wen  <= 1'b0;
        end else begin
            r_ack    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_sd_ren <= 1'b0;
            r_sd_wen <= 1'b0;
            if (w_grant) begin
                r_owner          <= w_gnt_port;
                r_wr             <= i_wr[w_gnt_port];
                r_blk_num        <= w_gnt_blk;
                r_adr            <= w_gnt_adr;
                r_cnt            <= '0;
                r_last           <= w_gnt_port;
                r_ack[w_gnt_port] <= 1'b1;
            end
            if (r_state == S_XFER) begin
                r_cnt <= w_cnt_next;
            end
            if (r_state == S_ISSUE) begin
                r_sd_ren <= ~r_wr;
                r_sd_wen <= r_wr;
            end
            if (w_done_set) begin
                r_done[r_owner] <= 1'b1;
                r_err           <= w_err_set;
            end
        end
    end

    assign o_ack        = r_ack;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_sd_ren     = r_sd_ren;
    assign o_sd_wen     = r_sd_wen;
    assign o_sd_blk_num = r_blk_num;
    assign o_sd_adr     = r_adr;
    assign o_busy       = (r_state != S_IDLE);

    // Byte steering follows the latched owner; the other port never sees strobes.
    assign o_rd_data = i_sd_data;
    assign o_rd_en   = {r_owner & w_rd_xfer, ~r_owner & w_rd_xfer};
    assign o_wr_req  = {r_owner & w_wr_xfer, ~r_owner & w_wr_xfer};
    assign o_sd_data = o_busy ? (r_owner ? i_wdata[15:8] : i_wdata[7:0]) : 8'd0;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Randomized scoreboard bench for sd_access_arbiter with a behavioural SD controller
// model and two requester ports; expectations are queued at grant and popped on outputs.
module tb_sd_access_arbiter;

    localparam int unsigned BLK = 512;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_req;
    logic [1:0]  i_wr;
    logic [63:0] i_blk_num;
    logic [63:0] i_adr;
    logic [15:0] i_wdata;
    logic [1:0]  o_ack, o_done, o_rd_en, o_wr_req;
    logic        o_err, o_busy, o_sd_ren, o_sd_wen;
    logic [7:0]  o_rd_data, o_sd_data;
    logic [31:0] o_sd_blk_num, o_sd_adr;
    logic        i_sd_ready, i_sd_data_en, i_sd_data_ready;
    logic [7:0]  i_sd_data;

    sd_access_arbiter #(.BLK_BYTES(BLK)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wr(i_wr),
        .i_blk_num(i_blk_num), .i_adr(i_adr), .i_wdata(i_wdata),
        .o_ack(o_ack), .o_done(o_done), .o_err(o_err), .o_rd_data(o_rd_data),
        .o_rd_en(o_rd_en), .o_wr_req(o_wr_req), .o_busy(o_busy),
        .o_sd_ren(o_sd_ren), .o_sd_wen(o_sd_wen), .o_sd_blk_num(o_sd_blk_num),
        .o_sd_adr(o_sd_adr), .o_sd_data(o_sd_data), .i_sd_ready(i_sd_ready),
        .i_sd_data(i_sd_data), .i_sd_data_en(i_sd_data_en),
        .i_sd_data_ready(i_sd_data_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        int port;
        bit err;
    } done_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_posted = 0;
    int          n_done = 0;
    int          strobe_cnt = 0;
    logic [1:0]  p_req = 2'b00;
    bit          p_wr [2];
    logic [31:0] p_blk [2];
    logic [31:0] p_adr [2];
    bit          p_short [2];
    int          p_idx [2];
    int          p_rep [2];
    bit          ack_seen [2];
    logic [1:0]  req_prev = 2'b00;
    bit          ref_last = 1'b1;
    int          cur = 0;
    bit          cur_wr = 1'b0;
    bit          cur_short = 1'b0;
    logic [31:0] cur_blk = '0;
    logic [31:0] cur_adr = '0;
    int          ack_cyc = 0;
    int          rise_cyc = 0;
    bit          prev_ready = 1'b1;
    bit          strobe_seen = 1'b0;
    int          wrreq_cnt = 0;
    done_t       exp_done_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  cap_q [$];
    int          grant_log [$];

    function automatic logic [7:0] wbyte(input int p, input int k);
        return 8'((k * 7 + p * 53 + k / 256) & 255);
    endfunction

    assign i_req     = p_req;
    assign i_wr      = {p_wr[1], p_wr[0]};
    assign i_blk_num = {p_blk[1], p_blk[0]};
    assign i_adr     = {p_adr[1], p_adr[0]};
    assign i_wdata   = {wbyte(1, p_idx[1]), wbyte(0, p_idx[0])};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic post(input int p, input bit wr, input logic [31:0] blk,
                        input logic [31:0] adr, input bit sh, input int rep);
        p_wr[p]    = wr;
        p_blk[p]   = blk;
        p_adr[p]   = adr;
        p_short[p] = sh;
        p_idx[p]   = 0;
        p_rep[p]   = rep;
        p_req[p]   = 1'b1;
        n_posted   = n_posted + 1 + rep;
    endtask

    task automatic wait_all(input int budget);
        int t = 0;
        while (n_done < n_posted && t < budget) begin
            @(posedge i_clk);
            t++;
        end
        check("all_done_in_time", 64'(n_done), 64'(n_posted));
        repeat (2) @(posedge i_clk);
        #2;
    endtask

    // Controller model plus port drivers, acting 2 time units after each rising edge.
    initial begin
        int   m_st = 0;
        int   m_left = 0;
        int   m_gap = 0;
        bit   m_wr = 1'b0;
        logic [7:0] m_k = 8'd0;
        i_sd_ready = 1'b1;
        i_sd_data = 8'd0;
        i_sd_data_en = 1'b0;
        i_sd_data_ready = 1'b0;
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                m_st = 0;
                i_sd_ready = 1'b1;
                i_sd_data = 8'd0;
                i_sd_data_en = 1'b0;
                i_sd_data_ready = 1'b0;
                p_req = 2'b00;
                ack_seen[0] = 1'b0;
                ack_seen[1] = 1'b0;
            end else begin
                #2;
                for (int p = 0; p < 2; p++) begin
                    if (ack_seen[p]) begin
                        ack_seen[p] = 1'b0;
                        if (p_rep[p] > 0) p_rep[p]--;
                        else p_req[p] = 1'b0;
                    end
                    if (o_wr_req[p]) p_idx[p]++;
                end
                i_sd_data_en = 1'b0;
                i_sd_data_ready = 1'b0;
                case (m_st)
                    0: if (strobe_seen) begin
                        strobe_seen = 1'b0;
                        m_wr   = cur_wr;
                        m_left = int'(cur_blk) * BLK - (cur_short ? 1 : 0);
                        m_gap  = $urandom_range(0, 2);
                        m_k    = 8'd0;
                        m_st   = 1;
                    end
                    1: if (m_gap == 0) begin
                        i_sd_ready = 1'b0;
                        m_gap = $urandom_range(1, 3);
                        m_st  = 2;
                    end else m_gap--;
                    default: if (m_left == 0) begin
                        i_sd_ready = 1'b1;
                        m_st = 0;
                    end else if (m_gap == 0) begin
                        if (m_wr) begin
                            i_sd_data_ready = 1'b1;
                            m_gap = 15;
                        end else begin
                            i_sd_data = m_k;
                            i_sd_data_en = 1'b1;
                            m_k++;
                            m_gap = $urandom_range(1, 2);
                        end
                        m_left--;
                    end else m_gap--;
                endcase
            end
        end
    end

    // Monitor: samples on the falling edge and checks against queued expectations.
    initial begin
        int    w;
        int    mism;
        done_t e;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                ref_last = 1'b1;
                exp_done_q.delete();
                exp_rd_q.delete();
                cap_q.delete();
                strobe_seen = 1'b0;
                prev_ready = 1'b1;
            end else begin
                if (i_sd_ready && !prev_ready) rise_cyc = cyc;
                prev_ready = i_sd_ready;
                if (i_sd_data_ready) cap_q.push_back(o_sd_data);
                if (o_done != 2'b00) begin
                    if (exp_done_q.size() == 0) begin
                        check("done_unexpected", 64'(o_done), 64'd0);
                    end else begin
                        e = exp_done_q.pop_front();
                        check("done_port", 64'(o_done), 64'(2'b01 << e.port));
                        check("done_err", 64'(o_err), 64'(e.err));
                        if (cur_blk != 0) check("done_latency", 64'(cyc), 64'(rise_cyc + 1));
                        else check("zero_done_latency", 64'(cyc - ack_cyc <= 2), 64'd1);
                        if (!cur_wr) begin
                            check("rd_bytes_left", 64'(exp_rd_q.size()), 64'd0);
                        end else begin
                            check("wr_req_count", 64'(wrreq_cnt), 64'(int'(cur_blk) * BLK));
                            check("wr_capture_count", 64'(cap_q.size()), 64'(int'(cur_blk) * BLK));
                            mism = 0;
                            foreach (cap_q[k]) if (cap_q[k] !== wbyte(cur, k)) mism++;
                            check("wr_data_mismatches", 64'(mism), 64'd0);
                        end
                        n_done++;
                    end
                end else if (o_err) begin
                    check("err_without_done", 64'(o_err), 64'd0);
                end
                if (o_ack != 2'b00) begin
                    check("ack_while_outstanding", 64'(exp_done_q.size()), 64'd0);
                    w = (req_prev == 2'b11) ? int'(!ref_last) : int'(req_prev[1]);
                    check("ack_port", 64'(o_ack), 64'(2'b01 << w));
                    ref_last  = w[0];
                    cur       = w;
                    cur_wr    = p_wr[w];
                    cur_blk   = p_blk[w];
                    cur_adr   = p_adr[w];
                    cur_short = p_short[w];
                    ack_cyc   = cyc;
                    ack_seen[w] = 1'b1;
                    grant_log.push_back(w);
                    exp_done_q.push_back('{port: w, err: (cur_blk == 0) || cur_short});
                    exp_rd_q.delete();
                    if (!cur_wr) begin
                        for (int k = 0; k < int'(cur_blk) * BLK - (cur_short ? 1 : 0); k++)
                            exp_rd_q.push_back(8'(k));
                    end
                    cap_q.delete();
                    wrreq_cnt = 0;
                end
                if (o_sd_ren || o_sd_wen) begin
                    strobe_cnt++;
                    check("strobe_nonzero_blk", 64'(cur_blk != 0), 64'd1);
                    check("strobe_cycle", 64'(cyc), 64'(ack_cyc + 1));
                    check("strobe_dir", 64'({o_sd_wen, o_sd_ren}), cur_wr ? 64'd2 : 64'd1);
                    check("sd_blk_num", 64'(o_sd_blk_num), 64'(cur_blk));
                    check("sd_adr", 64'(o_sd_adr), 64'(cur_adr));
                    strobe_seen = 1'b1;
                end
                if (o_rd_en != 2'b00) begin
                    check("rd_en_port", 64'(o_rd_en), 64'(2'b01 << cur));
                    if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(o_rd_en), 64'd0);
                    else check("rd_data", 64'(o_rd_data), 64'(exp_rd_q.pop_front()));
                end
                if (o_wr_req != 2'b00) begin
                    check("wr_req_port", 64'(o_wr_req), 64'(2'b01 << cur));
                    wrreq_cnt++;
                end
            end
            req_prev = i_req;
        end
    end

    initial begin
        int t;
        int gl0;
        int s0;
        int d0;
        int writes;
        int mask;
        bit wr;
        bit sh;
        logic [31:0] blk;
        for (int p = 0; p < 2; p++) begin
            p_wr[p] = 1'b0; p_blk[p] = '0; p_adr[p] = '0;
            p_short[p] = 1'b0; p_idx[p] = 0; p_rep[p] = 0; ack_seen[p] = 1'b0;
        end
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_ack_done_err", 64'({o_ack, o_done, o_err}), 64'd0);
        check("reset_rd_en_wr_req", 64'({o_rd_en, o_wr_req}), 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_strobes", 64'({o_sd_ren, o_sd_wen}), 64'd0);
        check("reset_sd_cmd", {o_sd_blk_num, o_sd_adr}, 64'd0);
        check("reset_data", 64'({o_sd_data, o_rd_data}), 64'd0);
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;

        // Single-block read on port 0, then a two-block write on port 1.
        post(0, 1'b0, 32'd1, 32'h10, 1'b0, 0);
        wait_all(20000);
        post(1, 1'b1, 32'd2, $urandom, 1'b0, 0);
        wait_all(40000);

        // Fresh reset, then both ports keep requesting: grants must alternate 0,1,0,1.
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        n_posted = n_done;
        @(posedge i_clk);
        #4;
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;
        gl0 = grant_log.size();
        post(0, 1'b0, 32'd1, $urandom, 1'b0, 1);
        post(1, 1'b0, 32'd1, $urandom, 1'b0, 1);
        wait_all(20000);
        check("rr_grant_count", 64'(grant_log.size() - gl0), 64'd4);
        for (int i = 0; i < 4 && gl0 + i < grant_log.size(); i++)
            check("rr_grant_order", 64'(grant_log[gl0 + i]), 64'(i % 2));

        // Zero-block request never strobes the controller; short read flags an error.
        s0 = strobe_cnt;
        post(0, 1'b0, 32'd0, 32'h20, 1'b0, 0);
        wait_all(100);
        check("zero_blk_no_strobe", 64'(strobe_cnt - s0), 64'd0);
        post(0, 1'b0, 32'd1, 32'h30, 1'b1, 0);
        wait_all(20000);

        // Reset in the middle of a read: outputs clear at once and no completion follows.
        post(0, 1'b0, 32'd1, 32'h40, 1'b0, 0);
        t = 0;
        while (exp_rd_q.size() > 400 && t < 5000) begin
            @(posedge i_clk);
            t++;
        end
        check("reached_xfer", 64'(exp_rd_q.size() <= 400), 64'd1);
        @(posedge i_clk);
        #3;
        d0 = n_done;
        i_rst = 1'b1;
        #1;
        check("midxfer_reset_outputs",
              64'({o_ack, o_done, o_err, o_rd_en, o_wr_req, o_busy, o_sd_ren, o_sd_wen, o_sd_data, o_rd_data}),
              64'd0);
        check("midxfer_reset_cmd", {o_sd_blk_num, o_sd_adr}, 64'd0);
        n_posted = n_done;
        repeat (3) @(posedge i_clk);
        #4;
        i_rst = 1'b0;
        repeat (5) @(posedge i_clk);
        check("no_done_after_reset", 64'(n_done), 64'(d0));
        #2;
        post(0, 1'b0, 32'd1, 32'h50, 1'b0, 0);
        wait_all(20000);

        // Randomized mix of ports, directions, sizes and short reads.
        writes = 0;
        for (int it = 0; it < 8; it++) begin
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    wr  = (writes < 2) ? 1'($urandom % 2) : 1'b0;
                    blk = wr ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 2));
                    sh  = !wr && (blk != 0) && ($urandom % 4 == 0);
                    if (wr && blk != 0) writes++;
                    post(p, wr, blk, $urandom, sh, 0);
                end
            end
            wait_all(40000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
